// File: rtl/bumpy_move_scheduler.sv
// Move scheduler: captures key presses, queues them and issues one motion command per landing.
// Optional CMD_QUEUE_EN selects a QUEUE_DEPTH FIFO instead of a single newest-wins holding register.
module bumpy_move_scheduler #(
    parameter int QUEUE_DEPTH        = 4,
    parameter int AIR_TIMEOUT_FRAMES = 90,
    parameter int SETTLE_FRAMES      = 2
) (
    input  logic                           clk,
    input  logic                           resetN,
    input  logic                           startOfFrame,
    input  logic                           keyRightN,
    input  logic                           keyLeftN,
    input  logic                           keyJumpN,
    input  logic                           collision,
    input  logic [3:0]                     HitEdgeCode,
    output logic                           cmdRightN,
    output logic                           cmdLeftN,
    output logic                           cmdJumpN,
    output logic                           respawnN,
    output logic                           busy,
    output logic [$clog2(QUEUE_DEPTH):0]   queueCount,
    output logic                           dropPulse
);
    localparam int CW = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [9:0] AIR_LIMIT = 10'(AIR_TIMEOUT_FRAMES);
    localparam logic [3:0] SET_LIMIT = 4'(SETTLE_FRAMES);
    localparam logic [1:0] CMD_RIGHT = 2'b01;
    localparam logic [1:0] CMD_LEFT  = 2'b10;
    localparam logic [1:0] CMD_JUMP  = 2'b11;

    typedef enum logic [1:0] {GROUNDED, ISSUE, AIRBORNE, SETTLE} state_t;

    state_t      state_reg, state_next;
    logic [9:0]  air_cnt_reg, air_cnt_next;
    logic [3:0]  set_cnt_reg, set_cnt_next;
    logic [1:0]  cmd_reg;
    logic [2:0]  key_reg, key_dly_reg;
    logic [2:0]  press;
    logic        push, pop, flush, do_push, drop_next;
    logic [1:0]  push_cmd, head_cmd;
    logic        respawn_reg, drop_reg;
    logic        unused_edges;

    assign unused_edges = &{1'b0, HitEdgeCode[3:1]};

    // Key bits packed as {jump, right, left}; released level is 1
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            key_reg     <= 3'b111;
            key_dly_reg <= 3'b111;
        end else begin
            key_reg     <= {keyJumpN, keyRightN, keyLeftN};
            key_dly_reg <= key_reg;
        end
    end

    assign press = key_dly_reg & ~key_reg;

    always_comb begin
        push     = |press;
        push_cmd = CMD_LEFT;
        if (press[2])      push_cmd = CMD_JUMP;
        else if (press[1]) push_cmd = CMD_RIGHT;
    end

`ifdef CMD_QUEUE_EN
    localparam int AW = $clog2(QUEUE_DEPTH);

    logic [1:0]    mem [QUEUE_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          full;

    assign full      = (count_reg == CW'(QUEUE_DEPTH));
    assign do_push   = push && !flush && (!full || pop);
    assign drop_next = push && !do_push;
    assign head_cmd  = mem[rd_ptr_reg];
    assign queueCount = count_reg;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= push_cmd;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (do_push && !pop)      count_reg <= count_reg + 1'b1;
            else if (pop && !do_push) count_reg <= count_reg - 1'b1;
        end
    end
`else
    logic       hold_valid_reg;
    logic [1:0] hold_cmd_reg;

    assign do_push    = push && !flush;
    assign drop_next  = push && (flush || (hold_valid_reg && !pop));
    assign head_cmd   = hold_cmd_reg;
    assign queueCount = {{(CW-1){1'b0}}, hold_valid_reg};

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hold_valid_reg <= 1'b0;
            hold_cmd_reg   <= 2'b00;
        end else if (flush) begin
            hold_valid_reg <= 1'b0;
        end else if (do_push) begin
            hold_valid_reg <= 1'b1;
            hold_cmd_reg   <= push_cmd;
        end else if (pop) begin
            hold_valid_reg <= 1'b0;
        end
    end
`endif

    always_comb begin
        state_next   = state_reg;
        air_cnt_next = air_cnt_reg;
        set_cnt_next = set_cnt_reg;
        pop          = 1'b0;
        flush        = 1'b0;
        case (state_reg)
            GROUNDED: begin
                if (startOfFrame && (queueCount != '0)) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (startOfFrame) begin
                    air_cnt_next = '0;
                    state_next   = AIRBORNE;
                end
            end
            AIRBORNE: begin
                // Landing has priority over a timeout on the same clock
                if (collision && HitEdgeCode[0]) begin
                    set_cnt_next = '0;
                    state_next   = SETTLE;
                end else if (startOfFrame) begin
                    if (air_cnt_reg + 10'd1 >= AIR_LIMIT) begin
                        flush        = 1'b1;
                        air_cnt_next = '0;
                        state_next   = GROUNDED;
                    end else begin
                        air_cnt_next = air_cnt_reg + 10'd1;
                    end
                end
            end
            SETTLE: begin
                if (SET_LIMIT == 4'd0) begin
                    state_next = GROUNDED;
                end else if (startOfFrame) begin
                    if (set_cnt_reg + 4'd1 >= SET_LIMIT) state_next = GROUNDED;
                    else set_cnt_next = set_cnt_reg + 4'd1;
                end
            end
            default: state_next = GROUNDED;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_reg   <= GROUNDED;
            air_cnt_reg <= '0;
            set_cnt_reg <= '0;
            cmd_reg     <= 2'b00;
            respawn_reg <= 1'b0;
            drop_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            air_cnt_reg <= air_cnt_next;
            set_cnt_reg <= set_cnt_next;
            if (pop) cmd_reg <= head_cmd;
            respawn_reg <= flush;
            drop_reg    <= drop_next;
        end
    end

    // Outputs decode from state so an async reset releases a pending command at once
    assign cmdRightN = !((state_reg == ISSUE) && (cmd_reg == CMD_RIGHT));
    assign cmdLeftN  = !((state_reg == ISSUE) && (cmd_reg == CMD_LEFT));
    assign cmdJumpN  = !((state_reg == ISSUE) && (cmd_reg == CMD_JUMP));
    assign respawnN  = !respawn_reg;
    assign busy      = (state_reg != GROUNDED);
    assign dropPulse = drop_reg;

endmodule

// File: tb/tb_bumpy_move_scheduler.sv
// Scoreboard bench for bumpy_move_scheduler; expected issue order is queued at key press
// and popped when a command pulse appears. Follows CMD_QUEUE_EN like the design.
module tb_bumpy_move_scheduler;
`ifdef CMD_QUEUE_EN
    localparam int MODEL_DEPTH = 4;
`else
    localparam int MODEL_DEPTH = 1;
`endif

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       startOfFrame = 1'b0;
    logic       keyRightN = 1'b1;
    logic       keyLeftN = 1'b1;
    logic       keyJumpN = 1'b1;
    logic       collision = 1'b0;
    logic [3:0] HitEdgeCode = 4'd0;
    logic       cmdRightN, cmdLeftN, cmdJumpN, respawnN, busy, dropPulse;
    logic [2:0] queueCount;

    int         total = 0;
    int         bad = 0;
    int         drop_seen = 0;
    int         resp_seen = 0;
    int         issues_seen = 0;
    int         model_drops = 0;
    int         snap;
    logic [1:0] exp_q[$];
    logic [2:0] prev_cmds = 3'b111;

    bumpy_move_scheduler #(
        .QUEUE_DEPTH(4),
        .AIR_TIMEOUT_FRAMES(90),
        .SETTLE_FRAMES(2)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .startOfFrame(startOfFrame),
        .keyRightN(keyRightN),
        .keyLeftN(keyLeftN),
        .keyJumpN(keyJumpN),
        .collision(collision),
        .HitEdgeCode(HitEdgeCode),
        .cmdRightN(cmdRightN),
        .cmdLeftN(cmdLeftN),
        .cmdJumpN(cmdJumpN),
        .respawnN(respawnN),
        .busy(busy),
        .queueCount(queueCount),
        .dropPulse(dropPulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic model_push(input logic [1:0] c);
        if (exp_q.size() < MODEL_DEPTH) begin
            exp_q.push_back(c);
        end else begin
            model_drops++;
            if (MODEL_DEPTH == 1) exp_q[0] = c;
        end
    endtask

    // mask = {jump, right, left}
    task automatic press(input logic [2:0] mask);
        keyJumpN  = !mask[2];
        keyRightN = !mask[1];
        keyLeftN  = !mask[0];
        if (mask[2])      model_push(2'b11);
        else if (mask[1]) model_push(2'b01);
        else if (mask[0]) model_push(2'b10);
        tick(1);
        keyJumpN  = 1'b1;
        keyRightN = 1'b1;
        keyLeftN  = 1'b1;
        tick(3);
        $display("press mask=%b queueCount=%0d", mask, queueCount);
    endtask

    task automatic sof();
        startOfFrame = 1'b1;
        tick(1);
        startOfFrame = 1'b0;
        tick(3);
    endtask

    task automatic land();
        collision   = 1'b1;
        HitEdgeCode = 4'b0001;
        tick(1);
        collision   = 1'b0;
        HitEdgeCode = 4'b0000;
        tick(1);
        $display("landing busy=%0b", busy);
    endtask

    // Issue monitor: every new command pulse is matched against the scoreboard head
    always @(negedge clk) begin
        logic [2:0] cur;
        logic [1:0] code;
        cur = {cmdRightN, cmdLeftN, cmdJumpN};
        if (resetN) begin
            if (dropPulse) drop_seen++;
            if (!respawnN) resp_seen++;
            if (cur != 3'b111 && prev_cmds == 3'b111) begin
                issues_seen++;
                code = !cmdJumpN ? 2'b11 : (!cmdRightN ? 2'b01 : 2'b10);
                check("one_low", $countones(~cur), 1);
                if (exp_q.size() == 0) check("issue_unexpected", code, 0);
                else check("issue_cmd", code, exp_q.pop_front());
                $display("issue cmd=%b", code);
            end
        end
        prev_cmds = resetN ? cur : 3'b111;
    end

    initial begin
        // Reset and idle
        tick(3);
        check("rst_cmds", {cmdRightN, cmdLeftN, cmdJumpN}, 3'b111);
        check("rst_respawn", respawnN, 1);
        check("rst_busy", busy, 0);
        check("rst_count", queueCount, 0);
        resetN = 1'b1;
        tick(2);
        repeat (3) sof();
        check("idle_cmds", {cmdRightN, cmdLeftN, cmdJumpN}, 3'b111);
        check("idle_busy", busy, 0);
        check("idle_count", queueCount, 0);

        // Single right command, landing, settle
        press(3'b010);
        check("t2_count", queueCount, 1);
        snap = issues_seen;
        sof();
        check("t2_issued", issues_seen, snap + 1);
        check("t2_right_low", cmdRightN, 0);
        check("t2_busy", busy, 1);
        sof();
        check("t2_released", {cmdRightN, cmdLeftN, cmdJumpN}, 3'b111);
        check("t2_air_busy", busy, 1);
        land();
        sof();
        check("t2_settle1", busy, 1);
        sof();
        check("t2_settle2", busy, 0);

        // Five presses while airborne
        press(3'b001);
        sof();
        sof();
        snap = drop_seen;
        press(3'b010);
        press(3'b001);
        press(3'b100);
        press(3'b010);
        press(3'b001);
        check("t3_count", queueCount, exp_q.size());
        check("t3_drops", drop_seen - snap, model_drops);
        for (int g = 0; g < 8 && exp_q.size() > 0; g++) begin
            land();
            sof();
            sof();
            check("t3_grounded", busy, 0);
            snap = issues_seen;
            sof();
            check("t3_issued", issues_seen, snap + 1);
            sof();
            check("t3_count_after", queueCount, exp_q.size());
        end
        check("t3_drained", exp_q.size(), 0);
        land();
        sof();
        sof();
        check("t3_done_busy", busy, 0);

        // Jump and left together
        snap = drop_seen;
        keyJumpN = 1'b0;
        keyLeftN = 1'b0;
        model_push(2'b11);
        tick(1);
        keyJumpN = 1'b1;
        keyLeftN = 1'b1;
        tick(3);
        check("t4_count", queueCount, 1);
        check("t4_no_drop", drop_seen - snap, 0);
        sof();
        check("t4_jump_low", cmdJumpN, 0);

        // Airborne timeout with a pending command flushed
        sof();
        press(3'b010);
        check("t5_pending", queueCount, 1);
        snap = resp_seen;
        repeat (89) sof();
        check("t5_still_air", busy, 1);
        check("t5_no_resp", resp_seen - snap, 0);
        sof();
        exp_q.delete();
        check("t5_resp_once", resp_seen - snap, 1);
        check("t5_flushed", queueCount, 0);
        check("t5_busy", busy, 0);

        // Async reset during ISSUE
        press(3'b100);
        sof();
        check("t6_jump_low", cmdJumpN, 0);
        press(3'b010);
        #2;
        resetN = 1'b0;
        #1;
        check("t6_jump_rel", cmdJumpN, 1);
        check("t6_busy", busy, 0);
        check("t6_count", queueCount, 0);
        exp_q.delete();
        tick(2);
        resetN = 1'b1;
        tick(2);
        sof();
        check("t6_idle_cmds", {cmdRightN, cmdLeftN, cmdJumpN}, 3'b111);
        check("t6_idle_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
